dpsk_mod: RTL and testbench

Differential phase-shift-keying modulator for the DPSK chain. Sits directly downstream of the 20-sample sine carrier generator and upstream of the DAC interface. Accepts serial data bits over a valid/ready handshake, differentially encodes them, and emits each carrier sample either unchanged (phase 0) or inverted (phase π). Phase changes occur only on carrier-cycle boundaries.

---
 rtl/dpsk_mod.sv | 135 +++++++++++++
 tb/tb_dpsk_mod.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dpsk_mod.sv
// dpsk_mod: differential PSK modulator. Takes serial bits over a valid/ready
// handshake, differentially encodes them, and passes each carrier sample
// through unchanged (d=0) or inverted (d=1). Phase changes happen only on
// carrier-cycle boundaries, so each bit starts at carrier sample 0.
// Optional feature macro: DPSK_PREAMBLE_EN. When defined, every IDLE->RUN
// start first sends one reference bit period of plain carrier (d=0).
module dpsk_mod #(
  parameter int SAMPLES_PER_CYCLE = 20,
  parameter int CYCLES_PER_BIT    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sin_in,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [7:0] mod_out,
  output logic       sym_strobe,
  output logic       busy
);

  localparam int PH_W = (SAMPLES_PER_CYCLE > 1) ? $clog2(SAMPLES_PER_CYCLE) : 1;
  localparam int CY_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SAMPLES_PER_CYCLE - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(CYCLES_PER_BIT - 1);
  localparam logic [7:0]      MIDSCALE = 8'd128;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t          r_state;
  logic [PH_W-1:0] r_ph;
  logic [CY_W-1:0] r_cy;
  logic            r_d;
  logic            r_hold_bit;
  logic            r_hold_full;
  logic [7:0]      r_mod_out;
  logic            r_sym_strobe;

  logic w_ph_last;
  logic w_bit_end;
  logic w_accept;
  logic w_bit_start;

  assign w_ph_last   = (r_ph == PH_LAST);
  assign w_bit_end   = w_ph_last && (r_cy == CY_LAST);
  assign w_accept    = bit_valid && !r_hold_full;
  assign w_bit_start = (r_state == ST_RUN) && (r_ph == '0) && (r_cy == '0);

  assign bit_ready  = ~r_hold_full;
  assign busy       = (r_state == ST_RUN);
  assign mod_out    = r_mod_out;
  assign sym_strobe = r_sym_strobe;

  // Carrier phase counter (tracks the generator index) and per-bit cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ph <= '0;
      r_cy <= '0;
    end else begin
      r_ph <= w_ph_last ? '0 : r_ph + 1'b1;
      if (r_state == ST_IDLE) begin
        r_cy <= '0;
      end else if (w_ph_last) begin
        r_cy <= (r_cy == CY_LAST) ? '0 : r_cy + 1'b1;
      end
    end
  end

  // Holding register, differential state and IDLE/RUN sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_d         <= 1'b0;
      r_hold_bit  <= 1'b0;
      r_hold_full <= 1'b0;
    end else begin
      // Accept and load are mutually exclusive: accept needs an empty register,
      // load needs a full one.
      if (w_accept) begin
        r_hold_bit  <= bit_in;
        r_hold_full <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_ph_last && r_hold_full) begin
            r_state <= ST_RUN;
`ifdef DPSK_PREAMBLE_EN
            // Reference period of plain carrier; the held bit is loaded at
            // the next bit boundary and encoded against d_prev = 0.
            r_d <= 1'b0;
`else
            // d_prev is 0 in IDLE, so d_new = 0 ^ b = b.
            r_d         <= r_hold_bit;
            r_hold_full <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          if (w_bit_end) begin
            if (r_hold_full) begin
              r_d         <= r_d ^ r_hold_bit;
              r_hold_full <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_d     <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_d     <= 1'b0;
        end
      endcase
    end
  end

  // Registered modulated sample and bit-start strobe (one cycle after sin_in).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mod_out    <= MIDSCALE;
      r_sym_strobe <= 1'b0;
    end else begin
      if (r_state == ST_RUN) begin
        r_mod_out <= r_d ? ~sin_in : sin_in;
      end else begin
        r_mod_out <= MIDSCALE;
      end
      r_sym_strobe <= w_bit_start;
    end
  end

endmodule

// File: tb/tb_dpsk_mod.sv
// Self-checking bench for dpsk_mod with a 20-sample carrier table generator.
// Honours DPSK_PREAMBLE_EN to select the expected sequences.
module tb_dpsk_mod;

`ifdef DPSK_PREAMBLE_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  localparam logic [7:0] TBL [20] = '{
    8'd128, 8'd167, 8'd203, 8'd231, 8'd249, 8'd255, 8'd249, 8'd231, 8'd203, 8'd167,
    8'd128, 8'd89,  8'd53,  8'd25,  8'd7,   8'd1,   8'd7,   8'd25,  8'd53,  8'd89
  };

  logic       clk;
  logic       rst;
  logic [7:0] sin_in;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [7:0] mod_out;
  logic       sym_strobe;
  logic       busy;
  logic [4:0] gen_idx;

  int n_cmp = 0;
  int n_err = 0;
  int rc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carrier generator model: leaves reset on the same edge as the DUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) gen_idx <= '0;
    else      gen_idx <= (gen_idx == 5'd19) ? 5'd0 : gen_idx + 5'd1;
  end
  assign sin_in = TBL[gen_idx];

  dpsk_mod #(.SAMPLES_PER_CYCLE(20), .CYCLES_PER_BIT(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .sin_in     (sin_in),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .mod_out    (mod_out),
    .sym_strobe (sym_strobe),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Offer one bit at a negedge; returns at the negedge after the accepting edge.
  task automatic send_bit(input logic b);
    int n = 0;
    bit_in    = b;
    bit_valid = 1'b1;
    while (!bit_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bit_ready) check_eq("send_timeout_ready", 0, 1);
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic wait_strobe(input int bound, output bit ok);
    int n = 0;
    while (!sym_strobe && n < bound) begin
      @(negedge clk);
      n++;
    end
    ok = sym_strobe;
  endtask

  // Check nb bit periods of output; dpat[k] is the expected d for bit k.
  task automatic check_run(input int nb, input logic [7:0] dpat, input int rdy_lim,
                           output int rdy_cnt);
    bit ok;
    logic [7:0] e;
    int b;
    rdy_cnt = 0;
    wait_strobe(200, ok);
    check_eq("strobe_seen", int'(ok), 1);
    if (!ok) return;
    check_eq("strobe_phase", int'(gen_idx), 1);
    check_eq("busy_run", int'(busy), 1);
    for (int i = 0; i < nb * 80; i++) begin
      if (i > 0) @(negedge clk);
      b = i / 80;
      e = dpat[b] ? 8'(255 - int'(TBL[i % 20])) : TBL[i % 20];
      check_eq("mod_out", int'(mod_out), int'(e));
      check_eq("strobe", int'(sym_strobe), int'(i % 80 == 0));
      if (i < rdy_lim && bit_ready) rdy_cnt++;
    end
    @(negedge clk);
    check_eq("idle_out", int'(mod_out), 128);
    check_eq("idle_busy", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    int cnt;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    rst       = 1'b1;
    #1 rst = 1'b0;
    #1;
    check_eq("rst_mod_out", int'(mod_out), 128);
    check_eq("rst_strobe", int'(sym_strobe), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_ready", int'(bit_ready), 1);
    #10 rst = 1'b1;
    @(negedge clk);

    // Sequence 1,0,1,1 with valid held; also counts ready pulses (backpressure).
    fork
      begin
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
      end
      check_run(4 + P, (P == 1) ? 8'b0001_0110 : 8'b0000_1011, (3 + P) * 80 - 1, rc);
    join
    check_eq("ready_pulses", rc, 2 + P);

    // Underflow after a single 0, then a 1 encodes against a cleared d_prev.
    send_bit(1'b0);
    check_run(1 + P, 8'b0, 0, rc);
    send_bit(1'b1);
    check_run(1 + P, (P == 1) ? 8'b10 : 8'b01, 0, rc);

    // Boundary race: bit offered on the very edge the empty register underflows.
    send_bit(1'b0);
    wait_strobe(200, ok);
    check_eq("race_strobe", int'(ok), 1);
    repeat (P * 80 + 78) @(negedge clk);
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    check_eq("race_ready", int'(bit_ready), 1);
    @(negedge clk);
    bit_valid = 1'b0;
    check_eq("race_last", int'(mod_out), int'(TBL[19]));
    n   = 0;
    cnt = 0;
    @(negedge clk);
    while (!sym_strobe && n < 40) begin
      if (mod_out == 8'd128) cnt++;
      @(negedge clk);
      n++;
    end
    check_eq("race_restart", int'(sym_strobe), 1);
    check_eq("race_idle_len", cnt, 20);
    check_eq("race_phase", int'(gen_idx), 1);
    check_eq("race_first", int'(mod_out), (P == 1) ? int'(TBL[0]) : 255 - int'(TBL[0]));
    repeat ((P + 1) * 80 + 2) @(negedge clk);
    check_eq("race_end_busy", int'(busy), 0);
    check_eq("race_end_out", int'(mod_out), 128);

    // Asynchronous reset mid-RUN with a held bit pending.
    send_bit(1'b1);
    wait_strobe(200, ok);
    check_eq("rr_strobe", int'(ok), 1);
    repeat (10) @(negedge clk);
    bit_in    = 1'b0;
    bit_valid = 1'b1;
    repeat (2) @(negedge clk);
    bit_valid = 1'b0;
    check_eq("rr_held_ready", int'(bit_ready), 0);
    check_eq("rr_busy_pre", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    check_eq("rr_mod_out", int'(mod_out), 128);
    check_eq("rr_busy", int'(busy), 0);
    check_eq("rr_ready", int'(bit_ready), 1);
    check_eq("rr_strobe_low", int'(sym_strobe), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (100) @(negedge clk);
    check_eq("rr_post_busy", int'(busy), 0);
    check_eq("rr_post_out", int'(mod_out), 128);
    check_eq("rr_post_ready", int'(bit_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
